// File: rtl/meter_cmd_pkg.sv
// Shared command codes, FSM encoding and strobe decode for the meter command arbiter.
package meter_cmd_pkg;

  localparam int unsigned CMD_W           = 3;
  localparam int unsigned CNT_W           = 4;
  localparam int unsigned HOLDOFF_DEFAULT = 4;

  localparam logic [CMD_W-1:0] CMD_ADD1 = 3'd0;
  localparam logic [CMD_W-1:0] CMD_ADD2 = 3'd1;
  localparam logic [CMD_W-1:0] CMD_ADD3 = 3'd2;
  localparam logic [CMD_W-1:0] CMD_ADD4 = 3'd3;
  localparam logic [CMD_W-1:0] CMD_RST1 = 3'd4;
  localparam logic [CMD_W-1:0] CMD_RST2 = 3'd5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // One bit per meter strobe line
  typedef struct packed {
    logic rst2;
    logic rst1;
    logic add4;
    logic add3;
    logic add2;
    logic add1;
  } strobe_t;

  // Codes above RST2 have no meter action
  function automatic logic cmd_legal(input logic [CMD_W-1:0] cmd);
    return (cmd <= CMD_RST2);
  endfunction

  // Map a command code onto its single strobe line
  function automatic strobe_t cmd_decode(input logic [CMD_W-1:0] cmd);
    strobe_t s;
    s = '0;
    case (cmd)
      CMD_ADD1: s.add1 = 1'b1;
      CMD_ADD2: s.add2 = 1'b1;
      CMD_ADD3: s.add3 = 1'b1;
      CMD_ADD4: s.add4 = 1'b1;
      CMD_RST1: s.rst1 = 1'b1;
      CMD_RST2: s.rst2 = 1'b1;
      default:  s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/meter_cmd_arbiter_if.sv
// Request handshakes from the local panel and the remote port.
interface meter_cmd_arbiter_if;
  import meter_cmd_pkg::*;

  logic             loc_valid;
  logic [CMD_W-1:0] loc_cmd;
  logic             loc_ready;
  logic             rem_valid;
  logic [CMD_W-1:0] rem_cmd;
  logic             rem_ready;

  modport master (
    output loc_valid, loc_cmd, rem_valid, rem_cmd,
    input  loc_ready, rem_ready
  );

  modport slave (
    input  loc_valid, loc_cmd, rem_valid, rem_cmd,
    output loc_ready, rem_ready
  );
endinterface

// File: rtl/holdoff_timer.sv
// Down-counter that times the idle gap after an issued meter pulse.
module holdoff_timer
  import meter_cmd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] load,
  input  logic             start,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // Load on start, then count down to zero and stay there
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= load;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Last hold cycle is the one where the count reads one
  assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/meter_cmd_arbiter.sv
// Round-robin arbiter between local and remote command sources driving meter strobes.
module meter_cmd_arbiter
  import meter_cmd_pkg::*;
#(
  parameter int unsigned HOLDOFF = HOLDOFF_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  meter_cmd_arbiter_if.slave  req,
  output logic                add1,
  output logic                add2,
  output logic                add3,
  output logic                add4,
  output logic                rst1,
  output logic                rst2,
  output logic                busy,
  output logic                err_cmd
);

  logic [1:0]       state, state_nxt;
  logic [CMD_W-1:0] cmd_q, cmd_nxt;
  logic             last_rem, last_rem_nxt;
  strobe_t          strobe_q, strobe_nxt;
  logic             err_q, err_nxt;
  logic             busy_q, busy_nxt;
  logic             hold_start;
  logic             hold_done;
  logic             loc_grant, rem_grant;
  logic [CMD_W-1:0] sel_cmd;

  // Grant one requester while idle; the side not granted last wins a tie
  assign loc_grant = rst && (state == ST_IDLE) && req.loc_valid &&
                     (!req.rem_valid || last_rem);
  assign rem_grant = rst && (state == ST_IDLE) && req.rem_valid &&
                     (!req.loc_valid || !last_rem);
  assign sel_cmd   = loc_grant ? req.loc_cmd : req.rem_cmd;

  assign req.loc_ready = loc_grant;
  assign req.rem_ready = rem_grant;

  holdoff_timer u_holdoff (
    .clk   (clk),
    .rst   (rst),
    .load  (CNT_W'(HOLDOFF)),
    .start (hold_start),
    .done  (hold_done)
  );

  // State, captured command, grant pointer and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cmd_q    <= '0;
      last_rem <= 1'b1;
      strobe_q <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cmd_q    <= cmd_nxt;
      last_rem <= last_rem_nxt;
      strobe_q <= strobe_nxt;
      err_q    <= err_nxt;
      busy_q   <= busy_nxt;
    end
  end

  // Next state and next output values; strobes are set on the handshake edge so they show in ISSUE
  always_comb begin
    state_nxt    = state;
    cmd_nxt      = cmd_q;
    last_rem_nxt = last_rem;
    strobe_nxt   = '0;
    err_nxt      = 1'b0;
    hold_start   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (loc_grant || rem_grant) begin
          cmd_nxt      = sel_cmd;
          last_rem_nxt = rem_grant;
          strobe_nxt   = cmd_decode(sel_cmd);
          err_nxt      = !cmd_legal(sel_cmd);
          state_nxt    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cmd_legal(cmd_q)) begin
          hold_start = 1'b1;
          state_nxt  = ST_HOLD;
        end else begin
          state_nxt  = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (hold_done) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    busy_nxt = (state_nxt != ST_IDLE);
  end

  assign add1    = strobe_q.add1;
  assign add2    = strobe_q.add2;
  assign add3    = strobe_q.add3;
  assign add4    = strobe_q.add4;
  assign rst1    = strobe_q.rst1;
  assign rst2    = strobe_q.rst2;
  assign err_cmd = err_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_meter_cmd_arbiter.sv
// Self-checking bench for meter_cmd_arbiter: directed scenarios plus random traffic against a timing model.
module tb_meter_cmd_arbiter;

  localparam int HOLD = 4;

  logic clk;
  logic rst;
  logic add1, add2, add3, add4, rst1, rst2, busy, err_cmd;

  meter_cmd_arbiter_if bus ();

  meter_cmd_arbiter #(.HOLDOFF(HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (bus),
    .add1    (add1),
    .add2    (add2),
    .add3    (add3),
    .add4    (add4),
    .rst1    (rst1),
    .rst2    (rst2),
    .busy    (busy),
    .err_cmd (err_cmd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;

  // Compare one observed value with its expectation
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Cycle counter
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transaction-level reference: each handshake reserves the arbiter until a cycle number
  int         m_free      = 0;
  int         m_issue     = -1;
  logic [5:0] m_vec       = '0;
  logic       m_err       = 1'b0;
  logic       m_last_rem  = 1'b1;
  int         last_strobe = -1;
  int         strobe_cnt  = 0;
  int         legal_cnt   = 0;
  int         busy_cnt    = 0;
  int         err_cnt     = 0;
  int         hist_cyc[$];
  logic [5:0] hist_vec[$];
  int         hs_cyc[$];

  logic [5:0] obs_vec, exp_vec;
  logic       exp_err, exp_busy, exp_lr, exp_rr, lv, rv, is_legal;
  logic [2:0] win_cmd;

  // Sample all outputs mid-cycle and compare with the model
  always @(negedge clk) begin
    obs_vec = {rst2, rst1, add4, add3, add2, add1};
    lv = bus.loc_valid;
    rv = bus.rem_valid;
    if (!rst) begin
      check("rst_strobes", 32'(obs_vec), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err_cmd), 32'd0);
      check("rst_ready", 32'({bus.loc_ready, bus.rem_ready}), 32'd0);
      m_free      = 0;
      m_issue     = -1;
      m_last_rem  = 1'b1;
      last_strobe = -1;
    end else begin
      exp_vec  = (cyc == m_issue) ? m_vec : 6'd0;
      exp_err  = (cyc == m_issue) && m_err;
      exp_busy = (cyc < m_free);
      exp_lr   = !exp_busy && lv && (!rv || m_last_rem);
      exp_rr   = !exp_busy && rv && (!lv || !m_last_rem);
      check("strobes", 32'(obs_vec), 32'(exp_vec));
      check("err_cmd", 32'(err_cmd), 32'(exp_err));
      check("busy", 32'(busy), 32'(exp_busy));
      check("loc_ready", 32'(bus.loc_ready), 32'(exp_lr));
      check("rem_ready", 32'(bus.rem_ready), 32'(exp_rr));
      check("onehot", 32'($countones(obs_vec) <= 1), 32'd1);
      if (obs_vec != 6'd0) begin
        if (last_strobe >= 0) check("strobe_gap", 32'((cyc - last_strobe) >= HOLD + 2), 32'd1);
        last_strobe = cyc;
        strobe_cnt++;
        hist_cyc.push_back(cyc);
        hist_vec.push_back(obs_vec);
      end
      if (busy) busy_cnt++;
      if (err_cmd) err_cnt++;
      if (exp_lr || exp_rr) begin
        win_cmd    = exp_lr ? bus.loc_cmd : bus.rem_cmd;
        is_legal   = (win_cmd < 3'd6);
        m_last_rem = exp_rr;
        m_issue    = cyc + 1;
        m_vec      = is_legal ? 6'(32'd1 << win_cmd) : 6'd0;
        m_err      = !is_legal;
        m_free     = cyc + 2 + (is_legal ? HOLD : 0);
        if (is_legal) legal_cnt++;
        hs_cyc.push_back(cyc);
      end
    end
  end

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
  endtask

  // Hold a local request until it is accepted (bounded)
  task automatic send_loc(input logic [2:0] c);
    bit got;
    got = 1'b0;
    bus.loc_valid = 1'b1;
    bus.loc_cmd   = c;
    for (int i = 0; i < 40 && !got; i++) begin
      #2;
      got = bus.loc_ready;
      @(posedge clk);
      #1;
    end
    bus.loc_valid = 1'b0;
    check("loc_hs_timeout", 32'(got), 32'd1);
  endtask

  // Hold a remote request until it is accepted (bounded)
  task automatic send_rem(input logic [2:0] c);
    bit got;
    got = 1'b0;
    bus.rem_valid = 1'b1;
    bus.rem_cmd   = c;
    for (int i = 0; i < 40 && !got; i++) begin
      #2;
      got = bus.rem_ready;
      @(posedge clk);
      #1;
    end
    bus.rem_valid = 1'b0;
    check("rem_hs_timeout", 32'(got), 32'd1);
  endtask

  // Random local traffic that keeps valid/cmd stable until accepted
  task automatic rand_loc(input int n);
    bit hs;
    for (int i = 0; i < n; i++) begin
      if (!bus.loc_valid && $urandom_range(1, 0) == 1) begin
        bus.loc_valid = 1'b1;
        bus.loc_cmd   = 3'($urandom_range(7, 0));
      end
      #2;
      hs = bus.loc_ready;
      @(posedge clk);
      #1;
      if (hs) bus.loc_valid = 1'b0;
    end
    bus.loc_valid = 1'b0;
  endtask

  // Random remote traffic that keeps valid/cmd stable until accepted
  task automatic rand_rem(input int n);
    bit hs;
    for (int i = 0; i < n; i++) begin
      if (!bus.rem_valid && $urandom_range(1, 0) == 1) begin
        bus.rem_valid = 1'b1;
        bus.rem_cmd   = 3'($urandom_range(7, 0));
      end
      #2;
      hs = bus.rem_ready;
      @(posedge clk);
      #1;
      if (hs) bus.rem_valid = 1'b0;
    end
    bus.rem_valid = 1'b0;
  endtask

  int b, b_busy, b_err, b_str, b_leg, n;

  initial begin
    rst = 1'b1;
    bus.loc_valid = 1'b0;
    bus.loc_cmd   = '0;
    bus.rem_valid = 1'b0;
    bus.rem_cmd   = '0;
    #1;
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;

    // Single local ADD1
    b = hist_vec.size(); b_busy = busy_cnt;
    send_loc(3'd0);
    repeat (8) step();
    check("t1_count", 32'(hist_vec.size() - b), 32'd1);
    check("t1_vec", 32'(hist_vec[b]), 32'h01);
    check("t1_busy_cycles", 32'(busy_cnt - b_busy), 32'(1 + HOLD));

    // Simultaneous requests after reset: local first
    do_reset();
    b = hist_vec.size();
    fork
      send_loc(3'd2);
      send_rem(3'd5);
    join
    repeat (8) step();
    check("t2_count", 32'(hist_vec.size() - b), 32'd2);
    check("t2_first", 32'(hist_vec[b]), 32'h04);
    check("t2_second", 32'(hist_vec[b+1]), 32'h20);
    check("t2_spacing", 32'(hist_cyc[b+1] - hist_cyc[b]), 32'(HOLD + 2));

    // Continuous contention alternates
    b = hist_vec.size();
    fork
      begin send_loc(3'd1); send_loc(3'd1); end
      begin send_rem(3'd3); send_rem(3'd3); end
    join
    repeat (8) step();
    check("t3_count", 32'(hist_vec.size() - b), 32'd4);
    check("t3_g0", 32'(hist_vec[b]),   32'h02);
    check("t3_g1", 32'(hist_vec[b+1]), 32'h08);
    check("t3_g2", 32'(hist_vec[b+2]), 32'h02);
    check("t3_g3", 32'(hist_vec[b+3]), 32'h08);

    // Illegal remote code, then an immediate legal request
    b = hist_vec.size(); b_err = err_cnt;
    send_rem(3'd7);
    send_loc(3'd3);
    repeat (8) step();
    n = hs_cyc.size();
    check("t4_err_pulses", 32'(err_cnt - b_err), 32'd1);
    check("t4_count", 32'(hist_vec.size() - b), 32'd1);
    check("t4_vec", 32'(hist_vec[b]), 32'h08);
    check("t4_hs_gap", 32'(hs_cyc[n-1] - hs_cyc[n-2]), 32'd2);

    // Reset during ISSUE truncates and does not reissue
    send_loc(3'd4);
    check("t5_rst1_issue", 32'(rst1), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check("t5_rst1_async", 32'(rst1), 32'd0);
    check("t5_busy_async", 32'(busy), 32'd0);
    b = hist_vec.size();
    repeat (3) step();
    rst = 1'b1;
    repeat (10) step();
    check("t5_no_reissue", 32'(hist_vec.size() - b), 32'd0);

    // Random traffic on both ports
    b_str = strobe_cnt; b_leg = legal_cnt;
    fork
      rand_loc(500);
      rand_rem(500);
    join
    repeat (HOLD + 4) step();
    check("rand_strobe_count", 32'(strobe_cnt - b_str), 32'(legal_cnt - b_leg));
    check("rand_activity", 32'((legal_cnt - b_leg) > 10), 32'd1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
